// File: rtl/instr_loader_pkg.sv
// Shared types and default sizes for the instruction loader.
package instr_loader_pkg;

    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned MAX_WORDS  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StChk,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready link from the board-level byte source into the loader.
interface instr_loader_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);

endinterface

// File: rtl/instr_loader.sv
// Loads a counted, big-endian 16-bit word image into instruction RAM, holding the CPU meanwhile.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_loader_if.slave     bus,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_done,
    output logic              cpu_hold,
    output logic              load_err
);

`ifdef CHECKSUM_EN
    localparam state_e StTail = StChk;
`else
    localparam state_e StTail = StDone;
`endif

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              hold_q, hold_d;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W-1:0] idx_q;
    logic [7:0]        hi_q;
    logic              xfer;
    logic              last;
    logic [ADDR_W:0]   count_clamp;

    assign xfer        = bus.byte_valid && ready_q;
    assign last        = ({1'b0, idx_q} + 1'b1) >= n_q;
    assign count_clamp = (bus.byte_in > 8'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.byte_in[ADDR_W:0];

`ifdef CHECKSUM_EN
    logic [7:0] acc_q;
    logic       err_q, err_d;
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StCount;
            StCount: if (xfer) state_d = (count_clamp == '0) ? StTail : StHi;
            StHi:    if (xfer) state_d = StLo;
            StLo:    if (xfer) state_d = last ? StTail : StHi;
`ifdef CHECKSUM_EN
            StChk:   if (xfer) state_d = (bus.byte_in == acc_q) ? StDone : StErr;
`endif
            StDone, StErr: if (start) state_d = StCount;
            default: state_d = StIdle;
        endcase
    end

    // Flags are decoded from the next state so they can be registered without a cycle of lag.
    always_comb begin
        ready_d = 1'b0;
        done_d  = 1'b0;
        hold_d  = 1'b1;
`ifdef CHECKSUM_EN
        err_d   = 1'b0;
`endif
        case (state_d)
            StCount, StHi, StLo, StChk: ready_d = 1'b1;
            StDone: begin
                done_d = 1'b1;
                hold_d = 1'b0;
            end
`ifdef CHECKSUM_EN
            StErr:  err_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            hold_q       <= 1'b1;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            hi_q         <= '0;
`ifdef CHECKSUM_EN
            err_q        <= 1'b0;
            acc_q        <= '0;
`endif
        end else begin
            ready_q <= ready_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            wr_en   <= 1'b0;
`ifdef CHECKSUM_EN
            err_q   <= err_d;
`endif
            case (state_q)
                StCount: if (xfer) begin
                    n_q          <= count_clamp;
                    words_loaded <= '0;
                    idx_q        <= '0;
`ifdef CHECKSUM_EN
                    acc_q        <= '0;
`endif
                end
                StHi: if (xfer) begin
                    hi_q  <= bus.byte_in;
`ifdef CHECKSUM_EN
                    acc_q <= acc_q ^ bus.byte_in;
`endif
                end
                StLo: if (xfer) begin
                    wr_en        <= 1'b1;
                    wr_addr      <= idx_q;
                    wr_data      <= DATA_W'({hi_q, bus.byte_in});
                    words_loaded <= words_loaded + 1'b1;
`ifdef CHECKSUM_EN
                    acc_q        <= acc_q ^ bus.byte_in;
`endif
                    // Holding the index on the last word keeps N=DEPTH from wrapping.
                    if (!last) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = ready_q;
    assign load_done      = done_q;
    assign cpu_hold       = hold_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomised self-checking bench for instr_loader against a byte-stream image model.
module tb_instr_loader;

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  words_loaded;
    logic        load_done;
    logic        cpu_hold;
    logic        load_err;

    instr_loader_if bus ();

    instr_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .words_loaded (words_loaded),
        .load_done    (load_done),
        .cpu_hold     (cpu_hold),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [3:0]  wlog_addr[$];
    logic [15:0] wlog_data[$];
    int          wlog_cyc[$];
    int          xlog_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wlog_addr.push_back(wr_addr);
            wlog_data.push_back(wr_data);
            wlog_cyc.push_back(cyc);
        end
        if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) xlog_cyc.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
        xlog_cyc.delete();
    endtask

    function automatic bytes_t add_chk(input bytes_t s);
        bytes_t r;
        logic [7:0] x;
        r = s;
        x = 8'h00;
        for (int i = 1; i < s.size(); i++) x ^= s[i];
`ifdef CHECKSUM_EN
        r.push_back(x);
`endif
        return r;
    endfunction

    function automatic bytes_t make_image(input logic [7:0] cnt);
        bytes_t s;
        int n;
        n = (cnt > 8'd16) ? 16 : int'(cnt);
        s.push_back(cnt);
        for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
        return add_chk(s);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // vmode: 0 = valid always, 1 = valid every other cycle, 2 = random valid.
    task automatic drive_stream(input bytes_t s, input int vmode, input bit noise, output bit ok);
        int  k = 0;
        int  budget = 0;
        bit  acc;
        while (k < s.size() && budget < 2000) begin
            case (vmode)
                0: bus.byte_valid = 1'b1;
                1: bus.byte_valid = (budget % 2) == 0;
                default: bus.byte_valid = $urandom_range(0, 1) == 1;
            endcase
            bus.byte_in = bus.byte_valid ? s[k] : 8'($urandom);
            start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            acc = bus.byte_valid && bus.byte_ready;
            tick();
            if (acc) k++;
            budget++;
        end
        start = 1'b0;
        bus.byte_valid = 1'b0;
        ok = (k == s.size());
    endtask

    task automatic test_load(input string name, input bytes_t s, input int vmode, input bit noise);
        int n;
        bit ok;
        n = (s[0] > 8'd16) ? 16 : int'(s[0]);
        clear_logs();
        pulse_start();
        drive_stream(s, vmode, noise, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s stream: byte transfer timed out", name);
        end
        // Surplus bytes must be held off once the image is complete.
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'hA5;
        repeat (3) tick();
        bus.byte_valid = 1'b0;
        checks++;
        if (xlog_cyc.size() != s.size()) begin
            failures++;
            $display("FAIL %s xfers: got %0d expected %0d", name, xlog_cyc.size(), s.size());
        end
        checks++;
        if (wlog_addr.size() != n) begin
            failures++;
            $display("FAIL %s nwrites: got %0d expected %0d", name, wlog_addr.size(), n);
        end
        for (int i = 0; i < n && i < wlog_addr.size(); i++) begin
            checks++;
            if (wlog_addr[i] !== 4'(i) || wlog_data[i] !== {s[1+2*i], s[2+2*i]}) begin
                failures++;
                $display("FAIL %s write%0d: got (%0d,%h) expected (%0d,%h)", name, i,
                         wlog_addr[i], wlog_data[i], i, {s[1+2*i], s[2+2*i]});
            end
            if (2 + 2 * i < xlog_cyc.size()) begin
                checks++;
                if (wlog_cyc[i] != xlog_cyc[2+2*i] + 1) begin
                    failures++;
                    $display("FAIL %s latency%0d: write cycle %0d expected %0d", name, i,
                             wlog_cyc[i], xlog_cyc[2+2*i] + 1);
                end
            end
        end
        checks++;
        if (words_loaded !== 5'(n) || load_done !== 1'b1 || cpu_hold !== 1'b0 ||
            bus.byte_ready !== 1'b0 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL %s status: words=%0d done=%b hold=%b ready=%b err=%b expected %0d 1 0 0 0",
                     name, words_loaded, load_done, cpu_hold, bus.byte_ready, load_err, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        repeat (2) tick();
        reset = 1'b0;
        clear_logs();
        checks++;
        if (cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 4'h0 ||
            wr_data !== 16'h0 || words_loaded !== 5'h0 || load_done !== 1'b0 || load_err !== 1'b0) begin
            failures++;
            $display("FAIL reset values: hold=%b ready=%b wr_en=%b addr=%h data=%h words=%0d done=%b err=%b",
                     cpu_hold, bus.byte_ready, wr_en, wr_addr, wr_data, words_loaded, load_done, load_err);
        end
        for (int i = 0; i < 5; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_in = 8'($urandom);
            tick();
            checks++;
            if (cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0) begin
                failures++;
                $display("FAIL idle%0d: hold=%b ready=%b expected 1 0", i, cpu_hold, bus.byte_ready);
            end
        end
        bus.byte_valid = 1'b0;
        checks++;
        if (wlog_addr.size() != 0 || xlog_cyc.size() != 0) begin
            failures++;
            $display("FAIL idle activity: writes=%0d xfers=%0d expected 0 0",
                     wlog_addr.size(), xlog_cyc.size());
        end
    endtask

    task automatic test_basic();
        bytes_t s;
        s = {8'h02, 8'h81, 8'h80, 8'h2C, 8'hB2};
        test_load("basic", add_chk(s), 0, 1'b0);
    endtask

    task automatic test_full();
        test_load("full", make_image(8'h20), 0, 1'b0);
    endtask

    task automatic test_toggle();
        test_load("toggle", make_image(8'h06), 1, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) test_load("random", make_image(8'($urandom_range(0, 20))), 2, 1'b1);
    endtask

    task automatic test_reset_mid();
        bytes_t s;
        bytes_t part;
        bit ok;
        s = make_image(8'h06);
        for (int i = 0; i < 8; i++) part.push_back(s[i]);
        clear_logs();
        pulse_start();
        drive_stream(part, 0, 1'b0, ok);
        // Reset lands on the same edge as the fourth word's low byte.
        bus.byte_valid = 1'b1;
        bus.byte_in = s[8];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.byte_valid = 1'b0;
        checks++;
        if (!ok || wr_en !== 1'b0 || wlog_addr.size() != 3) begin
            failures++;
            $display("FAIL midreset writes: ok=%b wr_en=%b writes=%0d expected 1 0 3",
                     ok, wr_en, wlog_addr.size());
        end
        checks++;
        if (cpu_hold !== 1'b1 || words_loaded !== 5'd0 || bus.byte_ready !== 1'b0 ||
            load_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset status: hold=%b words=%0d ready=%b done=%b expected 1 0 0 0",
                     cpu_hold, words_loaded, bus.byte_ready, load_done);
        end
        xlog_cyc.delete();
        bus.byte_valid = 1'b1;
        repeat (2) tick();
        bus.byte_valid = 1'b0;
        checks++;
        if (xlog_cyc.size() != 0) begin
            failures++;
            $display("FAIL midreset idle: xfers=%0d expected 0", xlog_cyc.size());
        end
        test_load("restart", make_image(8'h06), 0, 1'b0);
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        bytes_t good;
        bytes_t bad;
        bytes_t empty;
        bit ok;
        good  = {8'h01, 8'h12, 8'h34, 8'h26};
        bad   = {8'h01, 8'h12, 8'h34, 8'h27};
        empty = {8'h00, 8'h00};
        test_load("chk_good", good, 0, 1'b0);
        pulse_start();
        drive_stream(bad, 0, 1'b0, ok);
        checks++;
        if (!ok || load_err !== 1'b1 || cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0 ||
            load_done !== 1'b0) begin
            failures++;
            $display("FAIL chk_bad: ok=%b err=%b hold=%b ready=%b done=%b expected 1 1 1 0 0",
                     ok, load_err, cpu_hold, bus.byte_ready, load_done);
        end
        pulse_start();
        checks++;
        if (load_err !== 1'b0 || bus.byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL chk_clear: err=%b ready=%b hold=%b expected 0 1 1",
                     load_err, bus.byte_ready, cpu_hold);
        end
        drive_stream(empty, 0, 1'b0, ok);
        checks++;
        if (!ok || load_done !== 1'b1 || load_err !== 1'b0 || words_loaded !== 5'd0) begin
            failures++;
            $display("FAIL chk_empty: ok=%b done=%b err=%b words=%0d expected 1 1 0 0",
                     ok, load_done, load_err, words_loaded);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_toggle();
        test_random();
        test_reset_mid();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Program loader that fills the writable 16x16 instruction memory of the 16-bit MIPS core over a byte-stream valid/ready link.
- Assembles big-endian 16-bit words and drives the memory write port.
- Holds the CPU in reset until the image is complete.
- Sits between the board-level byte source and the instruction RAM. The RAM's read side stays word-indexed by pc[5:2].

Parameters:
DEPTH, 16, number of instruction words (max load size)
ADDR_W, 4, word-index width, log2(DEPTH)
DATA_W, 16, instruction width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle load request
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts byte this cycle
wr_en  output  1  instruction memory write strobe
wr_addr  output  ADDR_W  word index written (byte address = wr_addr*4)
wr_data  output  DATA_W  instruction word
words_loaded  output  ADDR_W+1  words written in current load
load_done  output  1  image complete
cpu_hold  output  1  CPU reset request
load_err  output  1  checksum failure (0 if feature absent)

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, words_loaded=0, load_done=0, load_err=0, cpu_hold=1.
  - State is IDLE.
- Transfer rule: a byte transfers only in a cycle where byte_valid && byte_ready. byte_ready=1 only in COUNT/HI/LO/CHK.
- States and transitions:
  - IDLE: start -> COUNT. cpu_hold=1.
  - COUNT: first byte gives N = min(byte,16). Sets words_loaded=0 and index=0.
    - N=0 -> CHK if CHECKSUM_EN is defined, else DONE.
    - N>0 -> HI.
  - HI: latch high byte -> LO.
  - LO: on transfer, next cycle drives wr_en=1 (one cycle), wr_data={hi,lo}, wr_addr=index. words_loaded increments with the strobe.
    - index+1 < N -> HI.
    - Otherwise -> CHK (feature) or DONE.
    - Write latency is 1 cycle after the low-byte transfer.
  - DONE: load_done=1, cpu_hold=0, byte_ready=0. start -> COUNT, clears load_done and sets cpu_hold=1.
- Boundaries and simultaneous events:
  - start outside IDLE/DONE/ERR is ignored.
  - Extra bytes after N words are not accepted (byte_ready=0).
  - index never exceeds DEPTH-1; N=16 writes indices 0..15 with no wrap.
  - byte_valid without start in IDLE is not accepted.
  - Reset mid-load returns to IDLE at once with reset outputs. Already-written words remain in memory; the loader never clears RAM.
  - A wr_en pulse pending at reset is suppressed.

Optional Feature:
CHECKSUM_EN defined:
- CHK state accepts one byte that must equal the XOR of all 2N data bytes (0x00 when N=0).
- Match -> DONE.
- Mismatch -> ERR: load_err=1, cpu_hold=1, byte_ready=0, load_done=0. Exit only via start (-> COUNT, clears load_err) or reset.
- XOR accumulator clears in COUNT.

Not defined: no CHK/ERR states, no accumulator, load_err tied 0.

Decomposition:
- Package instr_loader_pkg: state enum (IDLE, COUNT, HI, LO, CHK, DONE, ERR), DEPTH/ADDR_W/DATA_W defaults, MAX_WORDS=16.
- No sub-module inside the loader. The writable instr_ram it drives is a separate block in the same top.

Test Plan:
- Each scenario: stimulus -> required response.
- Reset, then idle 5 cycles -> cpu_hold=1, byte_ready=0, wr_en never asserted.
- start; bytes 0x02,0x81,0x80,0x2C,0xB2 -> writes (0,0x8180) and (1,0x2CB2), each 1 cycle after its low byte; words_loaded=2; load_done=1; cpu_hold=0.
- start; count 0x20; 32 bytes -> 16 writes at index 0..15; 33rd byte held off (byte_ready=0); load_done=1.
- byte_valid toggling every other cycle during the 6-word image -> identical writes; no byte lost or duplicated.
- Reset asserted after 3 words of a 6-word load -> next cycle IDLE, cpu_hold=1, words_loaded=0; then restart completes normally.
- CHECKSUM_EN: count 0x01, data 0x12,0x34, chk 0x26 -> DONE. Same load with chk 0x27 -> load_err=1, cpu_hold=1; start clears load_err.
